// File: rtl/riscv_wb_queue.sv
// In-order write-back queue between the dual-issue retire stage and the single
// register file write port, with two bypass lookup ports over pending entries.
module riscv_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s0_valid,
  input  logic [4:0]                 s0_rd,
  input  logic [31:0]                s0_data,
  input  logic                       s1_valid,
  input  logic [4:0]                 s1_rd,
  input  logic [31:0]                s1_data,
  output logic                       in_ready,
  output logic                       wb_wr_en,
  output logic [4:0]                 wb_rd_addr,
  output logic [31:0]                wb_rd_data,
  input  logic [4:0]                 lk_a_addr,
  output logic                       lk_a_hit,
  output logic [31:0]                lk_a_data,
  input  logic [4:0]                 lk_b_addr,
  output logic                       lk_b_hit,
  output logic [31:0]                lk_b_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: both slots are accepted in a cycle only when in_ready is high at
  // the rising edge; in_ready depends on registered occupancy alone, so a valid
  // presented while it is low is dropped and flagged in overflow_err.

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail1;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic          push0, push1, pop;

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign push0    = in_ready && s0_valid && (s0_rd != 5'd0);
  assign push1    = in_ready && s1_valid && (s1_rd != 5'd0);
  assign pop      = (count_q != '0);
  // slot1 lands right behind slot0, or in slot0's place when slot0 was not pushed
  assign tail1    = tail_q + PW'(push0);

  assign head_d     = head_q + PW'(pop);
  assign tail_d     = tail1 + PW'(push1);
  assign count_d    = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  assign overflow_d = overflow_q || (!in_ready && (s0_valid || s1_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever observed.
  always_ff @(posedge clk) begin
    if (push0) begin
      rd_mem_q[tail_q]   <= s0_rd;
      data_mem_q[tail_q] <= s0_data;
    end
    if (push1) begin
      rd_mem_q[tail1]   <= s1_rd;
      data_mem_q[tail1] <= s1_data;
    end
  end

  assign wb_wr_en     = pop;
  assign wb_rd_addr   = pop ? rd_mem_q[head_q]   : 5'd0;
  assign wb_rd_data   = pop ? data_mem_q[head_q] : 32'd0;
  assign count        = count_q;
  assign overflow_err = overflow_q;

  // Scan oldest to youngest so the last match wins, giving the youngest value.
  always_comb begin
    logic [PW-1:0] idx;
    logic          occ;
    idx       = '0;
    occ       = 1'b0;
    lk_a_hit  = 1'b0;
    lk_a_data = 32'd0;
    lk_b_hit  = 1'b0;
    lk_b_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      occ = (CW'(i) < count_q);
      if (occ && (lk_a_addr != 5'd0) && (rd_mem_q[idx] == lk_a_addr)) begin
        lk_a_hit  = 1'b1;
        lk_a_data = data_mem_q[idx];
      end
      if (occ && (lk_b_addr != 5'd0) && (rd_mem_q[idx] == lk_b_addr)) begin
        lk_b_hit  = 1'b1;
        lk_b_data = data_mem_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_queue.sv
// Directed bench for riscv_wb_queue: drain latency, x0 filtering, same-rd
// ordering, lookup, overflow, pointer wrap and asynchronous reset.
module tb_riscv_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s1_valid;
  logic [4:0]  s0_rd, s1_rd;
  logic [31:0] s0_data, s1_data;
  logic        in_ready, wb_wr_en;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic [4:0]  lk_a_addr, lk_b_addr;
  logic        lk_a_hit, lk_b_hit;
  logic [31:0] lk_a_data, lk_b_data;
  logic [2:0]  count;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  riscv_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data),
    .in_ready(in_ready), .wb_wr_en(wb_wr_en),
    .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .lk_a_addr(lk_a_addr), .lk_a_hit(lk_a_hit), .lk_a_data(lk_a_data),
    .lk_b_addr(lk_b_addr), .lk_b_hit(lk_b_hit), .lk_b_data(lk_b_data),
    .count(count), .overflow_err(overflow_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    s0_valid = v0; s0_rd = r0; s0_data = d0;
    s1_valid = v1; s1_rd = r1; s1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int mcount;
    int pops;
    int k;
    logic ready;
    logic [36:0] e;
    rst_n = 1'b0;
    idle();
    lk_a_addr = 5'd0;
    lk_b_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_wr_en", 32'(wb_wr_en), 32'd0);
    check("rst_addr", 32'(wb_rd_addr), 32'd0);
    check("rst_data", wb_rd_data, 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // single result into empty queue
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    step(); idle(); #1;
    check("t2_wr_en", 32'(wb_wr_en), 32'd1);
    check("t2_addr", 32'(wb_rd_addr), 32'd5);
    check("t2_data", wb_rd_data, 32'hDEADBEEF);
    check("t2_count", 32'(count), 32'd1);
    step();
    check("t2_empty_wr_en", 32'(wb_wr_en), 32'd0);
    check("t2_empty_count", 32'(count), 32'd0);

    // same rd in both slots
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
    step(); idle(); lk_a_addr = 5'd3; #1;
    check("t3_count", 32'(count), 32'd2);
    check("t3_addr0", 32'(wb_rd_addr), 32'd3);
    check("t3_data0", wb_rd_data, 32'h1);
    check("t3_lk_hit0", 32'(lk_a_hit), 32'd1);
    check("t3_lk_data0", lk_a_data, 32'h2);
    step();
    check("t3_addr1", 32'(wb_rd_addr), 32'd3);
    check("t3_data1", wb_rd_data, 32'h2);
    check("t3_lk_data1", lk_a_data, 32'h2);
    step();
    check("t3_lk_miss_hit", 32'(lk_a_hit), 32'd0);
    check("t3_lk_miss_data", lk_a_data, 32'd0);
    lk_a_addr = 5'd0;

    // x0 write discarded
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd0, 32'hFF);
    step(); idle(); lk_b_addr = 5'd0; #1;
    check("t4_count", 32'(count), 32'd1);
    check("t4_addr", 32'(wb_rd_addr), 32'd7);
    check("t4_data", wb_rd_data, 32'h77);
    check("t4_lk_b0", 32'(lk_b_hit), 32'd0);
    step();
    check("t4_count_after", 32'(count), 32'd0);
    check("t4_wr_en_after", 32'(wb_wr_en), 32'd0);

    // fill to count 3, then overflow
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    #1;
    check("t5_ready0", 32'(in_ready), 32'd1);
    step();
    check("t5_count2", 32'(count), 32'd2);
    check("t5_ready2", 32'(in_ready), 32'd1);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    step();
    check("t5_count3", 32'(count), 32'd3);
    check("t5_ready3", 32'(in_ready), 32'd0);
    check("t5_ovf_before", 32'(overflow_err), 32'd0);
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
    step(); idle(); lk_b_addr = 5'd5; #1;
    check("t5_ovf", 32'(overflow_err), 32'd1);
    check("t5_count_drop", 32'(count), 32'd2);
    check("t5_addr_x3", 32'(wb_rd_addr), 32'd3);
    check("t5_data_x3", wb_rd_data, 32'h33);
    check("t5_dropped_lk", 32'(lk_b_hit), 32'd0);
    step();
    check("t5_addr_x4", 32'(wb_rd_addr), 32'd4);
    check("t5_data_x4", wb_rd_data, 32'h44);
    step();
    check("t5_empty", 32'(wb_wr_en), 32'd0);
    check("t5_ovf_sticky", 32'(overflow_err), 32'd1);
    lk_b_addr = 5'd0;

    // sustained pairs across pointer wrap with a scoreboard
    mcount = 0;
    k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      check("t6_count", 32'(count), 32'(mcount));
      check("t6_wr_en", 32'(wb_wr_en), 32'(mcount != 0));
      ready = ((4 - mcount) >= 2);
      check("t6_ready", 32'(in_ready), 32'(ready));
      pops = 0;
      if (mcount != 0 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("t6_addr", 32'(wb_rd_addr), 32'(e[36:32]));
        check("t6_data", wb_rd_data, e[31:0]);
        pops = 1;
      end
      if (cyc < 30 && ready) begin
        drive(1'b1, 5'(k % 31 + 1), 32'hA000_0000 + 32'(k),
              1'b1, 5'((k + 1) % 31 + 1), 32'hA000_0000 + 32'(k + 1));
        exp_q.push_back({5'(k % 31 + 1), 32'hA000_0000 + 32'(k)});
        exp_q.push_back({5'((k + 1) % 31 + 1), 32'hA000_0000 + 32'(k + 1)});
        mcount = mcount - pops + 2;
        k += 2;
      end else begin
        idle();
        mcount = mcount - pops;
      end
      step();
    end
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check("t6_final_count", 32'(count), 32'd0);

    // asynchronous reset with entries queued
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    step(); idle(); lk_a_addr = 5'd9; #1;
    check("t1_pre_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t1_count", 32'(count), 32'd0);
    check("t1_wr_en", 32'(wb_wr_en), 32'd0);
    check("t1_lk_hit", 32'(lk_a_hit), 32'd0);
    check("t1_ovf", 32'(overflow_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t1_stay_empty", 32'(wb_wr_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
